alu_pipelined: RTL and testbench

//   Parametrised, registered successor to the 64-bit combinational ALU: XLEN-wide integer ALU

---
 rtl/alu_pipelined.sv | 186 ++++++++++++++++++
 tb/tb_alu_pipelined.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipelined.sv
// alu_pipelined: registered XLEN-wide integer ALU with valid/ready handshakes.
// Single-cycle ops register their result at the accept edge. MUL (op 10) runs
// an iterative shift-add sequence and is only present when ALU_MUL_EN is
// defined; otherwise op 10 is reported as illegal like opcodes 11..15.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no multiply in flight; accepts any op when output is free
// EXEC  | shift-add iteration, one bit of B consumed per cycle
// DONE  | product complete, loaded into the output register this cycle
module alu_pipelined #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] input1,
  input  logic [XLEN-1:0] input2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_out,
  output logic            zero,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] res_c;
  logic            ill_c;
  logic            mul_c;
  logic            accept;
  logic            idle;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  assign shamt = input2[SHW-1:0];

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;

  assign idle = (state_q == IDLE);
`else
  assign idle = 1'b1;
`endif

  // in_ready is forced low while reset is held.
  assign in_ready = rst_n && idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle result and opcode classification.
  always_comb begin
    res_c = '0;
    ill_c = 1'b0;
    mul_c = 1'b0;
    case (op)
      4'd0:    res_c = input1 + input2;
      4'd1:    res_c = input1 - input2;
      4'd2:    res_c = input1 & input2;
      4'd3:    res_c = input1 | input2;
      4'd4:    res_c = input1 ^ input2;
      4'd5:    res_c = input1 << shamt;
      4'd6:    res_c = input1 >> shamt;
      4'd7:    res_c = $unsigned($signed(input1) >>> shamt);
      4'd8:    res_c = {{(XLEN-1){1'b0}}, ($signed(input1) < $signed(input2))};
      4'd9:    res_c = {{(XLEN-1){1'b0}}, (input1 < input2)};
`ifdef ALU_MUL_EN
      4'd10:   mul_c = 1'b1;
`endif
      default: ill_c = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  // Multiply sequencer: next state and datapath for the shift-add loop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (accept && mul_c) begin
          state_d = EXEC;
          a_d     = input1;
          b_d     = input2;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      EXEC: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + SHW'(1);
        // Always runs the full XLEN iterations; no early exit on B == 0.
        if (cnt_q == SHW'(XLEN - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Multiply sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end
`endif

  // Output register next-state: consume, load single-cycle result, load product.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && !mul_c) begin
      out_valid_d = 1'b1;
      out_d       = res_c;
      zero_d      = (res_c == '0);
      illegal_d   = ill_c;
    end
`ifdef ALU_MUL_EN
    if (state_q == DONE) begin
      out_valid_d = 1'b1;
      out_d       = acc_q;
      zero_d      = (acc_q == '0);
      illegal_d   = 1'b0;
    end
`endif
  end

  // Output registers; ALU_out holds its last value after consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALU_out   = out_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipelined.sv
// tb_alu_pipelined: directed plus randomized checks of alu_pipelined (XLEN=64)
// against a plain-arithmetic reference model. Honors ALU_MUL_EN like the DUT.
module tb_alu_pipelined;
  localparam int XLEN = 64;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  localparam logic [63:0] SIGNBIT = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] input1;
  logic [XLEN-1:0] input2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALU_out;
  logic            zero;
  logic            illegal;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_r;

  alu_pipelined #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .input1(input1), .input2(input2), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_out(ALU_out), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the operation definitions, using plain arithmetic.
  function automatic void ref_alu(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic il);
    int s;
    s  = int'(b[5:0]);
    r  = 64'd0;
    il = 1'b0;
    case (o)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << s;
      4'd6: r = a >> s;
      4'd7: begin
        r = a >> s;
        if (a[63] && s != 0) r = r | ~(ONES >> s);
      end
      4'd8: r = ((a ^ SIGNBIT) < (b ^ SIGNBIT)) ? 64'd1 : 64'd0;
      4'd9: r = (a < b) ? 64'd1 : 64'd0;
      4'd10: begin
        if (MUL_ON) r = a * b;
        else il = 1'b1;
      end
      default: il = 1'b1;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] o);
    return (MUL_ON && o == 4'd10) ? XLEN + 1 : 1;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return ONES;
      2:       return SIGNBIT;
      3:       return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Present an op, wait (bounded) for in_ready, accept it, then scramble inputs.
  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    int w;
    w = 0;
    op = o; input1 = a; input2 = b; in_valid = 1'b1;
    #1;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    op = 4'($urandom);
    input1 = {$urandom, $urandom};
    input2 = {$urandom, $urandom};
  endtask

  // Called right after the accept edge; checks latency, result and flags.
  task automatic expect_result(input string tag, input logic [3:0] o, input logic [63:0] a,
                               input logic [63:0] b);
    logic [63:0] r;
    logic        il;
    int          bad;
    bad = 0;
    ref_alu(o, a, b, r, il);
    if (latency(o) > 1) begin
      for (int i = 0; i < latency(o); i++) begin
        if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
        tick();
      end
      chk({tag, "_busy"}, 64'(bad), 0);
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_ALU_out"}, ALU_out, r);
    chk({tag, "_zero"}, zero, (r == 64'd0));
    chk({tag, "_illegal"}, illegal, il);
    last_r = r;
  endtask

  // Optionally stall the consumer, then consume and check out_valid drops.
  task automatic drain(input int stall);
    if (stall > 0) begin
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < stall; i++) begin
        chk("hold_out_valid", out_valid, 1);
        chk("hold_ALU_out", ALU_out, last_r);
        chk("hold_in_ready", in_ready, 0);
        tick();
      end
      out_ready = 1'b1;
    end
    tick();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_ALU_out_kept", ALU_out, last_r);
  endtask

  initial begin
    int cnt;
    logic [3:0]  ro;
    logic [63:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; input1 = '0; input2 = '0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ALU_out", ALU_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // 1: ADD 1+0, valid for exactly one cycle.
    issue(4'd0, 64'd1, 64'd0);
    expect_result("add_1_0", 4'd0, 64'd1, 64'd0);
    drain(0);

    // 2: SUB then SRA back-to-back at one op per cycle.
    op = 4'd1; input1 = 64'd2; input2 = 64'd2; in_valid = 1'b1;
    #1;
    chk("b2b_in_ready0", in_ready, 1);
    tick();
    chk("b2b_sub_valid", out_valid, 1);
    chk("b2b_sub_out", ALU_out, 0);
    chk("b2b_sub_zero", zero, 1);
    chk("b2b_in_ready1", in_ready, 1);
    op = 4'd7; input1 = SIGNBIT; input2 = 64'd4;
    tick();
    in_valid = 1'b0;
    chk("b2b_sra_valid", out_valid, 1);
    chk("b2b_sra_out", ALU_out, 64'hF800_0000_0000_0000);
    chk("b2b_sra_zero", zero, 0);
    tick();
    chk("b2b_drain_valid", out_valid, 0);
    chk("b2b_drain_kept", ALU_out, 64'hF800_0000_0000_0000);

    // 3: ADD 5+6 held under backpressure while another op waits.
    out_ready = 1'b0;
    issue(4'd0, 64'd5, 64'd6);
    chk("stall_add_out", ALU_out, 64'd11);
    op = 4'd4; input1 = 64'hF0F0; input2 = 64'h0FF0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_out", ALU_out, 64'd11);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    expect_result("stall_next_xor", 4'd4, 64'hF0F0, 64'h0FF0);
    drain(0);

    // 4: MUL (or illegal op 10 when the multiplier is absent).
    issue(4'd10, 64'd5, 64'd6);
    expect_result("mul_5_6", 4'd10, 64'd5, 64'd6);
    if (MUL_ON) chk("mul_5_6_value", ALU_out, 64'd30);
    drain(0);
    issue(4'd10, ONES, 64'd2);
    expect_result("mul_ones_2", 4'd10, ONES, 64'd2);
    drain(1);

    // 5: illegal opcode 15.
    issue(4'd15, 64'h1234, 64'h5678);
    expect_result("op15", 4'd15, 64'h1234, 64'h5678);
    chk("op15_zero", zero, 1);
    chk("op15_illegal", illegal, 1);
    drain(0);

    // 6: asynchronous reset in the middle of a multiply.
    issue(4'd10, 64'd7, 64'd9);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ALU_out", ALU_out, 0);
    chk("mid_rst_zero", zero, 0);
    chk("mid_rst_illegal", illegal, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < XLEN + 4; i++) begin
      if (out_valid !== 1'b0) cnt++;
      tick();
    end
    chk("no_stale_result", 64'(cnt), 0);
    issue(4'd8, ONES, 64'd1);
    expect_result("slt_m1_1", 4'd8, ONES, 64'd1);
    chk("slt_m1_1_value", ALU_out, 64'd1);
    drain(0);
    issue(4'd9, ONES, 64'd1);
    expect_result("sltu_m1_1", 4'd9, ONES, 64'd1);
    chk("sltu_m1_1_value", ALU_out, 64'd0);
    drain(0);

    // Randomized ops with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      ro = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb);
      expect_result("rand", ro, ra, rb);
      drain($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
